rr_mux_arb: RTL
===============

// Module: rr_mux_arb
// PURPOSE
//   Parametrised N-channel, W-bit round-robin multiplexer with valid/ready handshake.
//   Generalises the fixed 4:1 16-bit select mux: the select is generated internally by a fair arbiter.
//   Output is registered.
//   Sits between multiple producers and a single shared consumer, e.g. a bus or a datapath port.
// PARAMETERS
//   WIDTH     16  data width per channel, >=1
//   CHANNELS  4   number of input channels, >=1
//   SEL_W     localparam = (CHANNELS>1) ? $clog2(CHANNELS) : 1
// PORTS
//   clk       in   1                 rising-edge clock
//   rst       in   1                 synchronous reset, active-high
//   in_data   in   CHANNELS*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  in   CHANNELS          channel i offers a word
//   in_ready  out  CHANNELS          channel i word accepted this cycle (valid&ready)
//   out_data  out  WIDTH             registered selected word
//   out_chan  out  SEL_W             index of channel that supplied out_data
//   out_valid out  1                 out_data/out_chan hold an unconsumed word
//   out_ready in   1                 consumer accepts word when out_valid&out_ready
// BEHAVIOUR
//   - One clock; rst is synchronous, active-high. No other reset.
//   - Reset values: out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. in_ready=0 while rst=1.
//   - load_ok = !out_valid | out_ready (the output register is empty or draining this cycle).
//   - Grant (combinational): search i = ptr, ptr+1, ... mod CHANNELS.
//     The first i with in_valid[i]=1 wins.
//     in_ready = onehot(winner) when load_ok & any valid & !rst, else all 0.
//   - At most one in_ready bit is high per cycle.
//     in_ready may depend combinationally on in_valid and out_ready.
//     There is no combinational path from in_data to any output.
//   - Transfer (any in_ready bit high) at edge:
//     out_data <= winner's word, out_chan <= winner, out_valid <= 1, ptr <= (winner+1) mod CHANNELS.
//   - No transfer and out_valid&out_ready: out_valid <= 0.
//     out_data and out_chan keep their last values.
//   - Stall (out_valid & !out_ready): out_data, out_chan, out_valid and ptr are held unchanged.
//     Every in_ready bit is 0.
//   - Latency: input accepted in cycle t appears on out_* in cycle t+1.
//     Throughput is 1 word/cycle when out_ready=1 continuously.
//   - Wrap-around: the pointer after channel CHANNELS-1 is 0.
//     ptr advances only on a transfer; idle cycles never move it.
//   - Fairness: a channel that holds in_valid=1 is granted within CHANNELS transfers.
//   - Simultaneous drain and load in the same cycle: the new word replaces the old one, with no bubble.
//   - Reset mid-operation: any held word is discarded (out_valid=0 next cycle) and ptr returns to 0.
//     Producers must re-offer data.
//   - CHANNELS=1: out_chan is constant 0 and the block reduces to a 1-deep pipeline register.
//   - Producers must hold in_valid/in_data stable until in_ready is high (standard valid/ready).
// TESTING (default WIDTH=16, CHANNELS=4)
//   1 Reset: rst=1 for 2 cycles with all in_valid=1 and out_ready=1.
//     -> out_valid=0, out_data=0, out_chan=0 and in_ready=0000 throughout.
//   2 Single channel: only ch2 valid with data 0x0003, out_ready=1.
//     -> in_ready=0100 in that cycle; next cycle out_valid=1, out_data=0x0003, out_chan=2.
//   3 Round robin: ch0..3 continuously valid with data 1,2,3,4, out_ready=1.
//     -> out_chan sequence 0,1,2,3,0,1 and out_data 1,2,3,4,1,2 on consecutive cycles.
//   4 Backpressure: hold out_ready=0 for 3 cycles while out_data=0x0002.
//     -> out_data and out_chan are stable and in_ready=0000.
//     Then raise out_ready -> the next grant is the channel after 1 (ch2 if valid).
//   5 Wrap: after a ch3 grant, only ch0 and ch3 are valid -> ch0 wins.
//     After that, only ch3 is valid -> ch3 wins, and ptr=0.
//   6 Reset mid-op: out_valid=1, out_ready=0, ptr=2, then rst=1 for 1 cycle.
//     -> next cycle out_valid=0.
//     With all channels valid, the first grant after reset is ch0.

Source files
------------

// File: rtl/rr_mux_arb.sv
// Round-robin N:1 multiplexer with valid/ready handshake on every port.
// Selection comes from an internal arbiter. The output word is registered and
// drains into a single consumer.
module rr_mux_arb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] win;
  logic             found;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] win_data;

  // The output register can take a new word when it is empty or being drained this cycle.
  assign load_ok = !valid_q || out_ready;

  // Rotating priority search starting at ptr_q. Channels below ptr_q are checked first so
  // that the channels at or above ptr_q override them. Each loop runs downwards so that
  // the lowest index in a group is the last one assigned.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) < ptr_q)) begin
        win   = SEL_W'(i);
        found = 1'b1;
      end
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
        win   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  // One-hot accept for the winner. It depends only on valids, out_ready, rst and state.
  always_comb begin
    in_ready = '0;
    if (load_ok && found && !rst) begin
      in_ready = CHANNELS'(1) << win;
    end
  end

  assign xfer = |in_ready;

  // Pick the winner's word. It only feeds the register, so in_data has no path to an output.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == win) begin
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: load on a transfer, empty on a plain drain, and hold otherwise.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = win_data;
      chan_d  = win;
      valid_d = 1'b1;
      if (win == SEL_W'(CHANNELS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + SEL_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset. Reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
